line_window_buf: RTL and testbench



---
 rtl/line_buf_pkg.sv | 31 +++
 rtl/line_ram.sv | 47 ++++
 rtl/line_window_buf.sv | 259 +++++++++++++++++++++++++
 tb/tb_line_window_buf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// ---------------------------------------------------------------------------
// line_buf_pkg
//   Shared definitions for the line_window_buf vertical window line buffer.
//
//   Contents:
//     DEFAULT_DATA_W / DEFAULT_LINE_W : default pixel width and line depth
//     line_cnt_t                      : range type for the "valid previous
//                                       lines" counter (0..TAPS)
//     bank_of_row()                   : which RAM bank holds output row j
//                                       given the current write bank
// ---------------------------------------------------------------------------
package line_buf_pkg;

    localparam int DEFAULT_DATA_W = 10;
    localparam int DEFAULT_LINE_W = 1280;

    // Wide enough for any practical TAPS value (up to 255 stored lines).
    localparam int LINE_CNT_W = 8;
    typedef logic [LINE_CNT_W-1:0] line_cnt_t;

    // Row j (1..taps) of the output column lives in bank (sel - j) mod taps.
    // Written without a modulo operator so that a variable 'sel' only costs a
    // subtract/add, and so row 'taps' maps onto the bank being overwritten.
    function automatic int bank_of_row(input int sel, input int row, input int taps);
        if (row > sel) begin
            return sel + taps - row;
        end
        return sel - row;
    endfunction

endpackage

// File: rtl/line_ram.sv
// ---------------------------------------------------------------------------
// line_ram
//   Single-clock simple dual-port line memory, DATA_W x DEPTH.
//   Synchronous read; a read and a write to the same address in one cycle
//   returns the OLD contents (read-before-write). Contents are not reset so
//   the array maps onto block RAM.
//
//   Ports:
//     clk      : clock, rising edge
//     i_we     : write enable
//     i_waddr  : write address
//     i_wdata  : write data
//     i_re     : read enable; o_rdata holds its value while i_re is low
//     i_raddr  : read address
//     o_rdata  : registered read data, valid the cycle after i_re
// ---------------------------------------------------------------------------
module line_ram #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 1280,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Both statements are non-blocking in the same block, so a same-address
    // read samples the array before the write lands: old-data semantics.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_window_buf.sv
// ---------------------------------------------------------------------------
// line_window_buf
//   Vertical window line buffer. Takes a raster pixel stream and, for every
//   accepted pixel, presents a column of TAPS+1 vertically aligned pixels:
//   the current pixel plus the same column of the TAPS previous lines.
//   TAPS line RAMs are used in rotation; the bank written on the current
//   line is also read (old data) to supply the oldest row.
//
//   Optional build macro: LINE_BUF_BORDER_REPLICATE_EN
//     defined   : rows above the available history repeat the oldest valid
//                 row (top-border replicate); o_win_valid == o_valid.
//     undefined : rows above the available history read as 0;
//                 o_win_valid only when all TAPS previous lines are real.
//
//   Ports:
//     CCD_PIXCLK  : pixel clock, all logic on the rising edge
//     RESET_N     : asynchronous active-low reset
//     in_fval     : frame valid
//     in_lval     : line valid
//     in_data     : pixel, taken when in_fval & in_lval and the line has room
//     o_taps      : row j at [j*DATA_W +: DATA_W]; j=0 current, j=TAPS oldest
//     o_valid     : o_taps/o_x/o_y describe an accepted pixel (1-cycle latency)
//     o_win_valid : o_valid with a fully populated window
//     o_x         : column of the pixel on o_taps
//     o_y         : line index in the frame of the pixel on o_taps
//     o_ovf       : sticky, a line in this frame exceeded LINE_W pixels
// ---------------------------------------------------------------------------
module line_window_buf
    import line_buf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int TAPS   = 2,
    parameter int ADDR_W = $clog2(LINE_W)
) (
    input  logic                       CCD_PIXCLK,
    input  logic                       RESET_N,
    input  logic                       in_fval,
    input  logic                       in_lval,
    input  logic [DATA_W-1:0]          in_data,
    output logic [(TAPS+1)*DATA_W-1:0] o_taps,
    output logic                       o_valid,
    output logic                       o_win_valid,
    output logic [ADDR_W-1:0]          o_x,
    output logic [15:0]                o_y,
    output logic                       o_ovf
);

    // Column counter needs one extra code to represent "line full" (LINE_W).
    localparam int                XW       = $clog2(LINE_W + 1);
    localparam int                SEL_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [XW-1:0]     X_LIMIT  = XW'(LINE_W);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(TAPS - 1);
    localparam line_cnt_t         LC_MAX   = line_cnt_t'(TAPS);

    // -----------------------------------------------------------------------
    // Input-side state
    // -----------------------------------------------------------------------
    logic [XW-1:0]     r_x_cnt;
    logic [15:0]       r_y_cnt;
    logic [SEL_W-1:0]  r_wr_sel;
    line_cnt_t         r_line_cnt;
    logic              r_lval_d;
    logic              r_fval_d;
    logic              r_ovf;

    // -----------------------------------------------------------------------
    // Output-stage registers, aligned with the RAM read data
    // -----------------------------------------------------------------------
    logic              r_valid;
    logic [ADDR_W-1:0] r_x;
    logic [15:0]       r_y;
    logic [DATA_W-1:0] r_row0;
    logic [SEL_W-1:0]  r_rd_sel;
    line_cnt_t         r_rd_lc;

    logic              w_fval_rise;
    logic              w_fval_fall;
    logic              w_line_end;
    logic [XW-1:0]     w_x_eff;
    logic [15:0]       w_y_eff;
    logic [SEL_W-1:0]  w_sel_eff;
    line_cnt_t         w_lc_eff;
    logic              w_x_room;
    logic              w_accept;
    logic              w_overflow;
    logic [ADDR_W-1:0] w_ram_addr;

    logic [DATA_W-1:0] w_rd_data [TAPS];
    logic [DATA_W-1:0] w_row_raw [TAPS+1];
    logic [DATA_W-1:0] w_row_out [TAPS+1];
    logic [DATA_W-1:0] w_row_fill;

    // -----------------------------------------------------------------------
    // Frame / line event decode
    // -----------------------------------------------------------------------
    assign w_fval_rise = in_fval & ~r_fval_d;
    assign w_fval_fall = ~in_fval & r_fval_d;
    assign w_line_end  = r_lval_d & ~in_lval & in_fval;

    // A frame start clears the position state in the same cycle it is seen,
    // so a pixel arriving on that cycle is placed at the start of a fresh
    // frame rather than wherever the counters happened to be.
    assign w_x_eff   = w_fval_rise ? '0 : r_x_cnt;
    assign w_y_eff   = w_fval_rise ? '0 : r_y_cnt;
    assign w_sel_eff = w_fval_rise ? '0 : r_wr_sel;
    assign w_lc_eff  = w_fval_rise ? '0 : r_line_cnt;

    assign w_x_room   = (w_x_eff < X_LIMIT);
    assign w_accept   = in_fval & in_lval & w_x_room;
    assign w_overflow = in_fval & in_lval & ~w_x_room;
    assign w_ram_addr = w_x_eff[ADDR_W-1:0];

    // -----------------------------------------------------------------------
    // Position counters, bank rotation, history depth, overflow flag
    // -----------------------------------------------------------------------
    always_ff @(posedge CCD_PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x_cnt    <= '0;
            r_y_cnt    <= '0;
            r_wr_sel   <= '0;
            r_line_cnt <= '0;
            r_lval_d   <= 1'b0;
            r_fval_d   <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_lval_d <= in_lval;
            r_fval_d <= in_fval;

            if (w_fval_fall) begin
                // Frame end wins over a line end falling in the same cycle:
                // the bank pointer is not advanced.
                r_x_cnt    <= '0;
                r_y_cnt    <= '0;
                r_wr_sel   <= '0;
                r_line_cnt <= '0;
            end else if (w_line_end && !w_fval_rise) begin
                r_x_cnt  <= '0;
                r_wr_sel <= (r_wr_sel == SEL_LAST) ? '0 : r_wr_sel + SEL_W'(1);
                if (r_y_cnt != 16'hFFFF) begin
                    r_y_cnt <= r_y_cnt + 16'd1;
                end
                if (r_line_cnt < LC_MAX) begin
                    r_line_cnt <= r_line_cnt + line_cnt_t'(1);
                end
            end else begin
                r_x_cnt    <= w_accept ? (w_x_eff + XW'(1)) : w_x_eff;
                r_y_cnt    <= w_y_eff;
                r_wr_sel   <= w_sel_eff;
                r_line_cnt <= w_lc_eff;
            end

            if (w_fval_rise) begin
                r_ovf <= 1'b0;
            end else if (w_overflow) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stage: captures everything that must line up with the RAM data
    // -----------------------------------------------------------------------
    always_ff @(posedge CCD_PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_valid  <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_row0   <= '0;
            r_rd_sel <= '0;
            r_rd_lc  <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_x      <= w_ram_addr;
                r_y      <= w_y_eff;
                r_row0   <= in_data;
                r_rd_sel <= w_sel_eff;
                r_rd_lc  <= w_lc_eff;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line RAM banks: all read on accept, only the current bank written
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_bank
            line_ram #(
                .DATA_W (DATA_W),
                .DEPTH  (LINE_W),
                .ADDR_W (ADDR_W)
            ) u_ram (
                .clk     (CCD_PIXCLK),
                .i_we    (w_accept && (w_sel_eff == SEL_W'(gi))),
                .i_waddr (w_ram_addr),
                .i_wdata (in_data),
                .i_re    (w_accept),
                .i_raddr (w_ram_addr),
                .o_rdata (w_rd_data[gi])
            );
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Row steering: map each output row onto the bank that holds it, using
    // the write bank captured at read time.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j <= TAPS; j++) begin
            w_row_raw[j] = '0;
        end
        w_row_raw[0] = r_row0;
        for (int j = 1; j <= TAPS; j++) begin
            for (int b = 0; b < TAPS; b++) begin
                if (b == bank_of_row(int'(r_rd_sel), j, TAPS)) begin
                    w_row_raw[j] = w_rd_data[b];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // History masking: rows deeper than the lines seen so far in this frame
    // hold stale RAM contents and are replaced.
    // -----------------------------------------------------------------------
    always_comb begin
        w_row_fill = '0;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
        // Replicate the oldest genuine row upward (top-border handling).
        for (int j = 0; j <= TAPS; j++) begin
            if (line_cnt_t'(j) == r_rd_lc) begin
                w_row_fill = w_row_raw[j];
            end
        end
`endif
        for (int j = 0; j <= TAPS; j++) begin
            w_row_out[j] = (line_cnt_t'(j) > r_rd_lc) ? w_row_fill : w_row_raw[j];
        end
    end

    generate
        for (genvar gi = 0; gi <= TAPS; gi++) begin : g_pack
            assign o_taps[gi*DATA_W +: DATA_W] = w_row_out[gi];
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_ovf   = r_ovf;

`ifdef LINE_BUF_BORDER_REPLICATE_EN
    assign o_win_valid = r_valid;
`else
    assign o_win_valid = r_valid & (r_rd_lc == LC_MAX);
`endif

endmodule

// File: tb/tb_line_window_buf.sv
// ---------------------------------------------------------------------------
// tb_line_window_buf
//   Drives two line_window_buf instances (TAPS=2 and TAPS=4, 8-bit pixels,
//   8-pixel lines) with the same raster stream. Expected outputs come from a
//   picture-level model: the pixels of the current frame are kept as
//   pix[line][column], and row j of an accepted pixel at (x, y) is simply
//   pix[y-j][x] when that line exists in the frame. Every frame keeps one
//   line width so every earlier line of the frame covers every column.
// ---------------------------------------------------------------------------
module tb_line_window_buf;

    localparam int DW   = 8;
    localparam int LW   = 8;
    localparam int AW   = $clog2(LW);
    localparam int MAXL = 16;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          fval;
    logic          lval;
    logic [DW-1:0] data;

    logic [3*DW-1:0] taps2;
    logic            valid2, win2, ovf2;
    logic [AW-1:0]   x2;
    logic [15:0]     y2;

    logic [5*DW-1:0] taps4;
    logic            valid4, win4, ovf4;
    logic [AW-1:0]   x4;
    logic [15:0]     y4;

    line_window_buf #(.DATA_W(DW), .LINE_W(LW), .TAPS(2)) u_dut2 (
        .CCD_PIXCLK  (clk),
        .RESET_N     (rst_n),
        .in_fval     (fval),
        .in_lval     (lval),
        .in_data     (data),
        .o_taps      (taps2),
        .o_valid     (valid2),
        .o_win_valid (win2),
        .o_x         (x2),
        .o_y         (y2),
        .o_ovf       (ovf2)
    );

    line_window_buf #(.DATA_W(DW), .LINE_W(LW), .TAPS(4)) u_dut4 (
        .CCD_PIXCLK  (clk),
        .RESET_N     (rst_n),
        .in_fval     (fval),
        .in_lval     (lval),
        .in_data     (data),
        .o_taps      (taps4),
        .o_valid     (valid4),
        .o_win_valid (win4),
        .o_x         (x4),
        .o_y         (y4),
        .o_ovf       (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] pix [MAXL][LW];
    bit            exp_valid;
    bit            exp_ovf;
    int            exp_x;
    int            exp_y;
    logic [DW-1:0] exp_d;
    int            frame_no = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected value of row j for the pixel currently expected on o_taps.
    function automatic logic [DW-1:0] exp_row(input int taps, input int j);
        int lc;
        int src;
        lc  = (exp_y < taps) ? exp_y : taps;
        src = j;
        if (j > lc) begin
            if (REPL) src = lc;
            else return '0;
        end
        if (src == 0) return exp_d;
        return pix[exp_y - src][exp_x];
    endfunction

    task automatic check_dut(input string nm, input int taps, input logic v, input logic w,
                             input logic [AW-1:0] x, input logic [15:0] y, input logic o,
                             input logic [5*DW-1:0] t);
        chk({nm, " o_valid"}, 32'(v), 32'(exp_valid));
        chk({nm, " o_win_valid"}, 32'(w), 32'(exp_valid && (REPL || exp_y >= taps)));
        chk({nm, " o_ovf"}, 32'(o), 32'(exp_ovf));
        if (exp_valid) begin
            chk({nm, " o_x"}, 32'(x), 32'(exp_x));
            chk({nm, " o_y"}, 32'(y), 32'(exp_y));
            for (int j = 0; j <= taps; j++) begin
                chk($sformatf("%s row%0d x=%0d y=%0d", nm, j, exp_x, exp_y),
                    32'(t[j*DW +: DW]), 32'(exp_row(taps, j)));
            end
        end
    endtask

    // One clock: apply inputs, then sample both DUTs 1 time unit after the edge.
    task automatic step(input bit f, input bit l, input logic [DW-1:0] d);
        fval = f;
        lval = l;
        data = d;
        @(posedge clk);
        #1;
        check_dut("taps2", 2, valid2, win2, x2, y2, ovf2, {16'b0, taps2});
        check_dut("taps4", 4, valid4, win4, x4, y4, ovf4, taps4);
    endtask

    task automatic pixel(input int y, input int x, input logic [DW-1:0] d);
        exp_valid = (x < LW);
        exp_x     = x;
        exp_y     = y;
        exp_d     = d;
        if (x < LW) pix[y][x] = d;
        else        exp_ovf = 1'b1;
        step(1'b1, 1'b1, d);
    endtask

    task automatic send_frame(input int nlines, input int width, input bit joint_fall, input bit pattern);
        logic [DW-1:0] d;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        step(1'b1, 1'b0, '0);
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < width; x++) begin
                d = pattern ? DW'(10 * y + x) : DW'($urandom);
                pixel(y, x, d);
            end
            exp_valid = 1'b0;
            if (y == nlines - 1 && joint_fall) begin
                step(1'b0, 1'b0, '0);
            end else begin
                repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, '0);
            end
        end
        if (!joint_fall) step(1'b0, 1'b0, '0);
        // Inter-frame idle, with line-valid noise that must be ignored.
        repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
        $display("frame %0d: lines=%0d width=%0d joint_fall=%0d overflow=%0d",
                 frame_no, nlines, width, joint_fall, (width > LW));
        frame_no++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        fval      = 1'b0;
        lval      = 1'b0;
        data      = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_x     = 0;
        exp_y     = 0;
        exp_d     = '0;

        // Reset state
        repeat (2) step(1'b0, 1'b0, '0);
        chk("reset taps2", 32'(taps2), 32'd0);
        chk("reset taps4", 32'(taps4[31:0]), 32'd0);
        chk("reset x4", 32'(x4), 32'd0);
        chk("reset y4", 32'(y4), 32'd0);
        rst_n = 1'b1;

        // Reset asserted in the middle of a line
        step(1'b1, 1'b0, '0);
        for (int x = 0; x < 4; x++) pixel(0, x, DW'($urandom));
        rst_n = 1'b0;
        #1;
        exp_valid = 1'b0;
        chk("async reset valid2", 32'(valid2), 32'd0);
        chk("async reset taps2", 32'(taps2), 32'd0);
        chk("async reset x2", 32'(x2), 32'd0);
        step(1'b1, 1'b1, 8'h55);
        chk("reset mid-line taps4", 32'(taps4[31:0]), 32'd0);
        step(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);

        // Directed frames
        send_frame(4, 8, 1'b0, 1'b1);   // 10*y+x pattern, rotation on line 3
        send_frame(3, 10, 1'b0, 1'b0);  // overflow: pixels 8 and 9 dropped
        send_frame(3, 5, 1'b1, 1'b0);   // line and frame valid fall together
        send_frame(5, 6, 1'b0, 1'b0);   // fresh history after the joint fall

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            send_frame($urandom_range(1, 7), $urandom_range(1, 10),
                       1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
